voice_slot_scheduler: RTL

Time-division scheduler that shares the single tone/sample generator between NUM_VOICES melodic voices (cello plus violins). Each voice owns a slot in a free-running round-robin; the block presents one voice's divider per clock to the shared generator. Per-voice note updates arrive over a valid/ready handshake into a shadow register. Updates commit at the voice's own slot, either immediately or aligned to the next beat strobe, so all voices change notes together on the beat.

---
 rtl/voice_slot_scheduler_pkg.sv | 7 +
 rtl/voice_slot_reg.sv | 48 ++++
 rtl/voice_slot_scheduler.sv | 52 +++++
 3 files changed

// File: rtl/voice_slot_scheduler_pkg.sv
// voice_slot_scheduler_pkg: shared voice/divider sizing for the scheduler, tone generator and sequencer
package voice_slot_scheduler_pkg;
  localparam int VSS_NUM_VOICES = 4;
  localparam int VSS_DIV_W      = 12;
  localparam int VSS_SLOT_W     = 2;
  localparam int DIV_SILENT     = 0;
endpackage

// File: rtl/voice_slot_reg.sv
// voice_slot_reg: per-voice shadow/armed/active divider state with commit at its own slot
module voice_slot_reg
  import voice_slot_scheduler_pkg::*;
#(
  parameter int DIV_W = VSS_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             note_valid,
  input  logic [DIV_W-1:0] note_div,
  output logic             note_ready,
  input  logic             sync_mode,
  input  logic             beat,
  input  logic             slot_hit,
  output logic [DIV_W-1:0] next_active,
  output logic             commit_pulse
);
  logic [DIV_W-1:0] shadow, active;
  logic             full, armed_q, armed, load, commit;
  assign note_ready  = !full;
  assign load        = note_valid && !full;
  assign armed       = armed_q || (full && !sync_mode);
  assign commit      = slot_hit && armed;
  assign next_active = commit ? shadow : active;
  // shadow load, beat arming and commit into the active divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow       <= DIV_W'(DIV_SILENT);
      active       <= DIV_W'(DIV_SILENT);
      full         <= 1'b0;
      armed_q      <= 1'b0;
      commit_pulse <= 1'b0;
    end else begin
      commit_pulse <= commit;
      if (commit) begin
        active  <= shadow;
        full    <= 1'b0;
        armed_q <= 1'b0;
      end else begin
        if (load) begin
          shadow <= note_div;
          full   <= 1'b1;
        end
        if (full && sync_mode && beat) armed_q <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/voice_slot_scheduler.sv
// voice_slot_scheduler: round-robin time sharing of one tone generator between melodic voices
module voice_slot_scheduler
  import voice_slot_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = VSS_NUM_VOICES,
  parameter int DIV_W      = VSS_DIV_W,
  parameter int SLOT_W     = VSS_SLOT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_VOICES-1:0]       note_valid,
  input  logic [NUM_VOICES*DIV_W-1:0] note_div,
  output logic [NUM_VOICES-1:0]       note_ready,
  input  logic [NUM_VOICES-1:0]       sync_mode,
  input  logic                        beat,
  input  logic [NUM_VOICES-1:0]       voice_en,
  output logic [DIV_W-1:0]            div_out,
  output logic [SLOT_W-1:0]           slot_out,
  output logic                        frame,
  output logic [NUM_VOICES-1:0]       commit_pulse
);
  logic [SLOT_W-1:0] slot_cnt;
  logic [DIV_W-1:0]  next_active [NUM_VOICES];
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    voice_slot_reg #(.DIV_W(DIV_W)) u_voice (
      .clk          (clk),
      .rst_n        (rst_n),
      .note_valid   (note_valid[g]),
      .note_div     (note_div[g*DIV_W +: DIV_W]),
      .note_ready   (note_ready[g]),
      .sync_mode    (sync_mode[g]),
      .beat         (beat),
      .slot_hit     (slot_cnt == SLOT_W'(g)),
      .next_active  (next_active[g]),
      .commit_pulse (commit_pulse[g])
    );
  end
  // free-running slot counter and registered presentation of the current slot's divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      slot_out <= '0;
      frame    <= 1'b0;
      div_out  <= DIV_W'(DIV_SILENT);
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
      slot_out <= slot_cnt;
      frame    <= slot_cnt == '0;
      div_out  <= voice_en[slot_cnt] ? next_active[slot_cnt] : DIV_W'(DIV_SILENT);
    end
  end
endmodule
